// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer slice.
//   mac_drv_state_t : sequencer FSM states
//   MODE_*          : mac_mode / job_mode encodings
//   FP16_*          : handy fp16 constants
package mac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCfg,
        StStream,
        StRead,
        StResp
    } mac_drv_state_t;

    localparam logic MODE_FP16 = 1'b1;
    localparam logic MODE_INT8 = 1'b0;

    localparam logic [15:0] FP16_ONE = 16'h3C00;
    localparam logic [15:0] FP16_TWO = 16'h4000;

endpackage

// File: rtl/mac_op_counter.sv
// Remaining-operand down-counter.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over dec)
//   dec        : decrement; ignored when already zero so the count never wraps
//   zero       : count is zero
//   last       : count is exactly one
module mac_op_counter #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] load_val,
    output logic             zero,
    output logic             last
);

    logic [LEN_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
    assign last = (count_q == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mac_seq_driver.sv
// Initiator-side sequencer for the non-pipelined int8/fp16 MAC.
// A job (mode, len) is accepted in idle; the MAC is cleared, configured, fed len operand
// pairs, read back, and the result plus sticky error is offered on res_*.
//   job_*  : job request handshake (job_ready high only when idle)
//   op_*   : operand pair stream
//   res_*  : result handshake, data/error held until res_ready
//   mac_*  : MAC control/data pins; mac_out/mac_error come back from the MAC
module mac_seq_driver
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic              job_mode,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error,
    output logic              mac_clr_n,
    output logic              mac_enable,
    output logic              mac_valid,
    output logic              mac_read,
    output logic              mac_cfg,
    output logic              mac_mode,
    output logic [DATA_W-1:0] mac_in_a,
    output logic [DATA_W-1:0] mac_in_b,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_error
);

    mac_drv_state_t    state_q, state_d;
    logic              mode_q;
    logic              clr_n_q;
    logic              seen_hs_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_error_q;
    logic              cnt_load;
    logic              cnt_zero;
    logic              cnt_last;
    logic              op_hs;

    assign op_hs = op_valid && op_ready;

    mac_op_counter #(
        .LEN_W (LEN_W)
    ) u_op_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (op_hs),
        .load_val (job_len),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        job_ready  = 1'b0;
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        mac_enable = 1'b0;
        mac_read   = 1'b0;
        mac_cfg    = 1'b0;
        cnt_load   = 1'b0;
        unique case (state_q)
            StIdle: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    cnt_load = 1'b1;
                    state_d  = StClear;
                end
            end
            StClear: state_d = StCfg;
            StCfg: begin
                mac_cfg = 1'b1;
                state_d = cnt_zero ? StRead : StStream;
            end
            StStream: begin
                mac_enable = 1'b1;
                op_ready   = !cnt_zero;
                if (op_hs && cnt_last) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                mac_enable = 1'b1;
                mac_read   = 1'b1;
                state_d    = StResp;
            end
            StResp: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= MODE_INT8;
            clr_n_q     <= 1'b1;
            seen_hs_q   <= 1'b0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Clear pin comes from a flop so it is glitch-free as a MAC reset term.
            clr_n_q <= (state_d != StClear);
            if (state_q == StIdle && job_valid) begin
                mode_q      <= job_mode;
                seen_hs_q   <= 1'b0;
                res_error_q <= 1'b0;
            end
            if (state_q == StStream) begin
                if (op_hs) begin
                    seen_hs_q <= 1'b1;
                end
                // MAC error is only meaningful once it holds real operands.
                if (seen_hs_q) begin
                    res_error_q <= res_error_q | mac_error;
                end
            end
            if (state_q == StRead) begin
                res_data_q  <= mac_out;
                res_error_q <= res_error_q | mac_error;
            end
        end
    end

    assign mac_clr_n = clr_n_q;
    assign mac_mode  = mode_q;
    assign mac_valid = op_hs;
    assign mac_in_a  = op_hs ? op_a : '0;
    assign mac_in_b  = op_hs ? op_b : '0;
    assign res_data  = res_data_q;
    assign res_error = res_error_q;

endmodule

// File: tb/tb_mac_seq_driver.sv
module tb_mac_seq_driver;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0, job_ready, job_mode = 1'b0;
    logic [7:0]  job_len = '0;
    logic        op_valid = 1'b0, op_ready;
    logic [15:0] op_a = '0, op_b = '0;
    logic        res_valid, res_ready = 1'b0, res_error;
    logic [15:0] res_data;
    logic        mac_clr_n, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode;
    logic [15:0] mac_in_a, mac_in_b, mac_out;
    logic        mac_error = 1'b0;

    mac_seq_driver #(.DATA_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode), .job_len(job_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_error(res_error),
        .mac_clr_n(mac_clr_n), .mac_enable(mac_enable), .mac_valid(mac_valid),
        .mac_read(mac_read), .mac_cfg(mac_cfg), .mac_mode(mac_mode),
        .mac_in_a(mac_in_a), .mac_in_b(mac_in_b), .mac_out(mac_out), .mac_error(mac_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // ---------------- fp16 / int8 arithmetic ----------------
    function automatic real f2r(input logic [15:0] h);
        int  e;
        real r;
        e = int'(h[14:10]);
        if (e == 0) begin
            r = real'(h[9:0]) / 16777216.0;
        end else begin
            r = 1.0 + real'(h[9:0]) / 1024.0;
            for (int i = 0; i < e - 15; i++) r = r * 2.0;
            for (int i = 0; i < 15 - e; i++) r = r / 2.0;
        end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2f(input real x);
        logic s;
        real  a;
        int   e;
        int   m;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 15;
        if (a == 0.0) return 16'h0000;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, e[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] mac_step(input logic m, input logic [15:0] acc,
                                             input logic [15:0] a, input logic [15:0] b);
        int p;
        if (m) return r2f(f2r(acc) + f2r(a) * f2r(b));
        p = $signed(a[7:0]) * $signed(b[7:0]);
        return acc + p[15:0];
    endfunction

    // ---------------- behavioural MAC ----------------
    logic [15:0] mac_acc;
    logic        mac_m;
    logic        mac_rst_n;
    assign mac_rst_n = rst_n & mac_clr_n;

    always @(posedge clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            mac_acc <= 16'h0;
            mac_m   <= 1'b0;
        end else begin
            if (mac_cfg) mac_m <= mac_mode;
            if (mac_enable && mac_valid) mac_acc <= mac_step(mac_m, mac_acc, mac_in_a, mac_in_b);
        end
    end
    assign mac_out = (mac_read && mac_enable && !mac_valid) ? mac_acc : 16'h0;

    // ---------------- job expectations ----------------
    logic [15:0] va[256];
    logic [15:0] vb[256];
    logic [15:0] exp_d[$];
    logic        exp_e[$];
    int          exp_len[$];
    logic        in_job = 1'b0;
    logic        prev_clr = 1'b1;
    logic        cur_mode = 1'b0;
    int          hs_cnt = 0;
    int          opr_cnt = 0;

    function automatic logic [15:0] model_result(input logic m, input int len);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < len; i++) acc = mac_step(m, acc, va[i], vb[i]);
        return acc;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the job-level model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("job_ready_idle", job_ready, !in_job);
            check("cfg_with_enable", mac_cfg & mac_enable, 0);
            check("read_with_valid", mac_read & mac_valid, 0);
            check("mac_valid_hs", mac_valid, op_valid & op_ready);
            check("mac_in_a", mac_in_a, mac_valid ? op_a : 16'h0);
            check("mac_in_b", mac_in_b, mac_valid ? op_b : 16'h0);
            check("enable_while_streaming", mac_enable | !op_ready, 1);
            check("cfg_after_clear", mac_cfg, !prev_clr);
            if (mac_cfg) check("cfg_mode", mac_mode, cur_mode);
            if (res_valid) begin
                if (exp_d.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    check("res_data", res_data, exp_d[0]);
                    check("res_error", res_error, exp_e[0]);
                end
            end
            if (op_ready) opr_cnt++;
            if (op_valid && op_ready) hs_cnt++;
            if (job_valid && job_ready) begin
                in_job  = 1'b1;
                hs_cnt  = 0;
                opr_cnt = 0;
            end
            if (res_valid && res_ready && exp_d.size() != 0) begin
                check("op_count", hs_cnt, exp_len[0]);
                void'(exp_d.pop_front());
                void'(exp_e.pop_front());
                void'(exp_len.pop_front());
                in_job = 1'b0;
            end
            prev_clr = mac_clr_n;
        end
    end

    // ---------------- driver ----------------
    logic [15:0] got_d;
    logic        got_e;
    int          got_lat;

    // Entered and left at posedge+2.
    task automatic run_job(input logic m, input int len, input int stall_at, input int stall_n,
                           input int resp_wait, input bit inj);
        int w;
        int acc_cyc;
        job_mode  = m;
        job_len   = len[7:0];
        job_valid = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!job_ready && w < 50);
        if (!job_ready) begin check("job_accept_timeout", 0, 1); job_valid = 1'b0; return; end
        acc_cyc  = cyc;
        cur_mode = m;
        exp_d.push_back(model_result(m, len));
        exp_e.push_back(inj);
        exp_len.push_back(len);
        @(posedge clk); #2;
        job_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                op_valid = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    mac_error = inj && (s == 0);
                    @(posedge clk); #2;
                end
                mac_error = 1'b0;
            end
            op_valid = 1'b1;
            op_a = va[i];
            op_b = vb[i];
            w = 0;
            do begin @(negedge clk); w++; end while (!op_ready && w < 50);
            if (!op_ready) begin check("op_timeout", 0, 1); op_valid = 1'b0; return; end
            @(posedge clk); #2;
        end
        op_valid = 1'b0;
        op_a = 16'h0;
        op_b = 16'h0;
        w = 0;
        do begin @(negedge clk); w++; end while (!res_valid && w < 600);
        if (!res_valid) begin check("res_timeout", 0, 1); return; end
        got_lat = cyc - acc_cyc;
        repeat (resp_wait) @(negedge clk);
        @(posedge clk); #2;
        res_ready = 1'b1;
        @(negedge clk);
        got_d = res_data;
        got_e = res_error;
        @(posedge clk); #2;
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_ctl"}, {job_ready, op_ready, res_valid, res_error, mac_clr_n, mac_enable,
                               mac_valid, mac_read, mac_cfg, mac_mode}, 10'b1000100000);
        check({name, "_res_data"}, res_data, 16'h0);
        check({name, "_mac_in"}, {mac_in_a, mac_in_b}, 32'h0);
    endtask

    logic [15:0] first_d;
    int          w0;

    initial begin
        #7;
        check_reset_outs("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // int8 (3,4),(5,6) -> 42
        va[0] = 16'd3; vb[0] = 16'd4; va[1] = 16'd5; vb[1] = 16'd6;
        run_job(MODE_INT8, 2, -1, 0, 0, 1'b0);
        check("t1_data", got_d, 16'h002A);
        check("t1_err", got_e, 0);
        check("t1_lat", got_lat, 6);

        // fp16 1*2 + 1.5*2 -> 5.0
        va[0] = FP16_ONE; vb[0] = FP16_TWO; va[1] = 16'h3E00; vb[1] = FP16_TWO;
        run_job(MODE_FP16, 2, -1, 0, 0, 1'b0);
        check("t2_data", got_d, 16'h4500);
        check("t2_lat", got_lat, 6);

        // int8 len=3, with and without a 4-cycle gap
        va[0] = 16'd2; vb[0] = 16'd5; va[1] = 16'd3; vb[1] = 16'd7; va[2] = 16'd4; vb[2] = 16'd1;
        run_job(MODE_INT8, 3, -1, 0, 0, 1'b0);
        first_d = got_d;
        check("t3_data", got_d, 16'h0023);
        check("t3_lat", got_lat, 7);
        run_job(MODE_INT8, 3, 1, 4, 0, 1'b0);
        check("t3_stall_data", got_d, first_d);
        check("t3_stall_lat", got_lat, 11);

        // error raised mid-stream sticks to the job
        va[0] = 16'd3; vb[0] = 16'd4; va[1] = 16'd5; vb[1] = 16'd6;
        run_job(MODE_INT8, 2, 1, 2, 0, 1'b1);
        check("t4_err_data", got_d, 16'h002A);
        check("t4_err", got_e, 1);

        // back-to-back; held result, then a job proving the clear
        run_job(MODE_INT8, 2, -1, 0, 5, 1'b0);
        check("t5_data", got_d, 16'h002A);
        check("t5_err_cleared", got_e, 0);
        va[0] = 16'd1; vb[0] = 16'd1;
        run_job(MODE_INT8, 1, -1, 0, 0, 1'b0);
        check("t5_job2_data", got_d, 16'h0001);
        check("t5_job2_lat", got_lat, 5);

        // len=0
        run_job(MODE_INT8, 0, -1, 0, 0, 1'b0);
        check("t6_len0_data", got_d, 16'h0000);
        check("t6_len0_lat", got_lat, 4);
        check("t6_len0_op_ready", opr_cnt, 0);

        // maximum length
        for (int i = 0; i < 256; i++) begin va[i] = 16'd1; vb[i] = 16'd1; end
        run_job(MODE_INT8, 255, -1, 0, 0, 1'b0);
        check("t7_max_data", got_d, 16'h00FF);
        check("t7_max_lat", got_lat, 259);

        // reset in the middle of a stream
        va[0] = 16'd2; vb[0] = 16'd3;
        job_mode = MODE_INT8; job_len = 8'd3; job_valid = 1'b1;
        @(posedge clk); #2;
        job_valid = 1'b0;
        op_valid = 1'b1; op_a = 16'd2; op_b = 16'd3;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!op_ready && w0 < 50);
        check("t8_reach_stream", op_ready, 1);
        @(posedge clk); #2;
        op_a = 16'd4; op_b = 16'd5;
        #1 rst_n = 1'b0;
        #1 check_reset_outs("t8_midreset");
        op_valid = 1'b0; op_a = 16'h0; op_b = 16'h0;
        exp_d.delete(); exp_e.delete(); exp_len.delete();
        in_job = 1'b0;
        prev_clr = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_job(MODE_INT8, 1, -1, 0, 0, 1'b0);
        check("t8_after_reset", got_d, 16'h0006);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
